// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of {pc, inst} entries with flush; head is read straight from storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush && !reset) mem[wr_ptr] <= din;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the fetch PC, pushes memory words into the prefetch queue, handles redirects.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [29:0]            imem_addr,
  input  logic [31:0]            imem_data,
  input  logic                   fetch_en,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic [31:0]            inst,
  output logic [31:0]            inst_pc,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [31:0]            fetch_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic         push;
  logic         pop;
  fetch_entry_t head;
  fetch_entry_t din;

  assign imem_addr  = fetch_pc[31:2];
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  // A full queue may still accept a word when the head leaves in the same cycle.
  assign push       = fetch_en && !redirect && ((count < CW'(DEPTH)) || pop);
  assign din        = '{pc: fetch_pc, inst: imem_data};
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (din),
    .head  (head),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a 256-word combinational memory model.
module tb_fetch_sequencer;

  logic        clock;
  logic        reset;
  logic [29:0] imem_addr;
  logic [31:0] imem_data;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] fetch_pc;
  logic [2:0]  count;

  logic [31:0] mem [256];
  int          compareCount;
  int          mismatchCount;

  fetch_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .fetch_pc    (fetch_pc),
    .count       (count)
  );

  assign imem_data = mem[imem_addr[7:0]];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's inputs, then let one rising edge pass and settle.
  task automatic applyStimulus(input logic rst, input logic en, input logic rdy,
                               input logic redir, input logic [31:0] rpc);
    reset       = rst;
    fetch_en    = en;
    inst_ready  = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    @(posedge clock);
    #1;
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc, input logic [31:0] word);
    checkOutput({tag, "_valid"}, 32'(inst_valid), 32'd1);
    checkOutput({tag, "_pc"}, inst_pc, pc);
    checkOutput({tag, "_inst"}, inst, word);
  endtask

  task automatic checkEmpty(input string tag);
    checkOutput({tag, "_valid"}, 32'(inst_valid), 32'd0);
    checkOutput({tag, "_count"}, 32'(count), 32'd0);
    checkOutput({tag, "_pc"}, inst_pc, 32'd0);
    checkOutput({tag, "_inst"}, inst, 32'd0);
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA0 + 32'(i);
    reset = 1'b1; fetch_en = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("rst_fetch_pc", fetch_pc, 32'h0040_0000);
    checkEmpty("rst");

    // Streaming with decode always ready: one word per cycle.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      checkHead($sformatf("stream%0d", k), 32'h0040_0000 + 32'(4 * k), 32'hA0 + 32'(k));
      checkOutput($sformatf("stream%0d_fpc", k), fetch_pc, 32'h0040_0004 + 32'(4 * k));
    end

    // Backpressure from a fresh reset: queue fills to 4 and fetch stalls.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput($sformatf("bp%0d_count", k), 32'(count), (k < 4) ? 32'(k) : 32'd4);
      checkOutput($sformatf("bp%0d_fpc", k), fetch_pc, 32'h0040_0000 + ((k < 4) ? 32'(4 * k) : 32'd16));
      checkHead($sformatf("bp%0d", k), 32'h0040_0000, 32'hA0);
    end

    // Full queue with pop and push together.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("fullpp_count", 32'(count), 32'd4);
    checkOutput("fullpp_fpc", fetch_pc, 32'h0040_0014);
    checkHead("fullpp", 32'h0040_0004, 32'hA1);

    // Drain with fetch disabled: in order, then empty, fetch_pc held.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      checkHead($sformatf("drain%0d", k), 32'h0040_0008 + 32'(4 * k), 32'hA2 + 32'(k));
      checkOutput($sformatf("drain%0d_count", k), 32'(count), 32'(3 - k));
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    checkEmpty("drained");
    checkOutput("drained_fpc", fetch_pc, 32'h0040_0014);

    // Redirect with three entries queued and a pop in the same cycle.
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("pre_redir_count", 32'(count), 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0040_0043);
    checkEmpty("redir");
    checkOutput("redir_imem_addr", 32'(imem_addr), 32'h0010_0010);
    checkOutput("redir_fpc", fetch_pc, 32'h0040_0040);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    checkHead("redir_tgt", 32'h0040_0040, 32'hB0);

    // Reset wins over redirect with a non-empty queue.
    checkOutput("pre_rst_count", 32'(count), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_1234);
    checkOutput("rst2_fetch_pc", fetch_pc, 32'h0040_0000);
    checkEmpty("rst2");

    // PC wrap at the top of the address space.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    checkOutput("wrap_fpc0", fetch_pc, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    checkHead("wrap_top", 32'hFFFF_FFFC, 32'h0000_019F);
    checkOutput("wrap_fpc1", fetch_pc, 32'h0000_0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    checkHead("wrap_zero", 32'h0000_0000, 32'hA0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that sequences the 256-word instruction memory for the single-cycle/pipelined MIPS cores. It owns the fetch PC, drives the memory's word address, captures returned instruction words into a small prefetch queue, and hands them to decode over a valid/ready handshake. It accepts branch/jump redirects, which flush the queue and restart fetch at the new target.

## Interface
- `RESET_PC`, default 32'h0040_0000: fetch PC loaded on reset; must be word-aligned.
- `DEPTH`, default 4: prefetch queue entries; power of two, ≥ 2.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `imem_addr` out 30: word address to instruction memory, equal to `fetch_pc[31:2]` (combinational).
- `imem_data` in 32: instruction word for `imem_addr`, valid in the same cycle (combinational read).
- `fetch_en` in 1: when 0, no new pushes; queue still drains.
- `redirect` in 1: one-cycle pulse; flush and restart at `redirect_pc`.
- `redirect_pc` in 32: new target; bits [1:0] ignored (treated as 0).
- `inst` out 32: instruction at queue head.
- `inst_pc` out 32: byte PC of `inst`.
- `inst_valid` out 1: queue non-empty.
- `inst_ready` in 1: decode accepts head this cycle.
- `fetch_pc` out 32: PC currently presented to memory.
- `count` out clog2(DEPTH)+1: queue occupancy.

## Operation
- Queue entry = {pc, inst}. Pop = `inst_valid && inst_ready`.
- Push = `fetch_en && !redirect && (count < DEPTH || pop)`; pushed entry is {`fetch_pc`, `imem_data`}; on push, `fetch_pc <= fetch_pc + 4`.
- Full with simultaneous pop: push permitted, `count` unchanged.
- Empty: no bypass; a word pushed in cycle N is visible on `inst` in N+1.
- Redirect (highest priority after reset): queue cleared (`count <= 0`, pointers reset), no push, `fetch_pc <= {redirect_pc[31:2], 2'b00}`. A pop in the redirect cycle is still a completed transfer from decode's view; the entry is discarded with the rest.
- `fetch_en` low: `fetch_pc` holds, queue drains normally; redirect still honoured.
- `fetch_pc` arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 → 0. Memory indexes only `imem_addr[7:0]`, so fetch past word 255 aliases to word 0; the sequencer does not detect this.
- Reset: `fetch_pc = RESET_PC`, `count = 0`, `inst_valid = 0`, `inst = 0`, `inst_pc = 0`; reset overrides redirect and push in the same cycle.
- Outputs `inst`/`inst_pc` are 0 whenever `inst_valid = 0`.

## Timing
- Reset deasserted before edge 0 with `fetch_en = 1`: push at edge 0, `inst_valid = 1` after edge 0 (latency 1 cycle).
- Steady state with `inst_ready` held 1: one instruction per cycle, `inst_pc` increments by 4 each cycle.
- Redirect asserted in cycle N: `inst_valid = 0` in N+1, `imem_addr = redirect_pc[31:2]` in N+1, target instruction on `inst` in N+2 (2-cycle redirect penalty).
- Backpressure: `inst_ready = 0` holds the head stable (`inst`, `inst_pc`, `inst_valid` unchanged) until accepted; fetch stops once `count = DEPTH`.

## Structure
- Shared package `fetch_pkg`: `RESET_PC` default, `fetch_entry_t` struct {pc[31:0], inst[31:0]}.
- Sub-module `fetch_fifo`: synchronous DEPTH-entry circular buffer with `push`, `pop`, `flush`, `count`, registered head; read/write pointers of clog2(DEPTH) bits wrapping modulo DEPTH. Top level holds PC register and push/redirect control.

## Test plan
- Reset then `fetch_en = 1`, `inst_ready = 1`, memory words 0..3 = 0xA0..0xA3: `inst_pc` = 0x00400000, 0x00400004, … from cycle 1, `inst` = memory[imem_addr] each.
- `inst_ready = 0` for 6 cycles: `count` rises 1..4 and saturates, `fetch_pc` stops at RESET_PC+16, head unchanged; release → drains in order with no loss/duplication.
- Full queue + pop + push same cycle: `count` stays 4, next head = next-oldest PC.
- Redirect to 0x00400043 while queue has 3 entries: next cycle `inst_valid = 0`, `imem_addr` = 0x00100010; following cycle `inst_pc` = 0x00400040.
- Reset asserted with `redirect = 1` and queue non-empty: after edge, `fetch_pc` = RESET_PC, `count` = 0, all outputs at reset values.
- `fetch_pc` forced via redirect to 0xFFFFFFFC: next pushed PC after it is 0x00000000.
